// File: rtl/conv_read_sequencer_pkg.sv
// Shared accelerator definitions: bus geometry, buffer address widths and the
// read-sequencer state encoding.
package conv_read_sequencer_pkg;

    localparam int WEIGHT_ADDR_WIDTH = 13;
    localparam int IMAGE_ADDR_WIDTH  = 10;
    localparam int CACHE_WIDTH       = 256;
    localparam int NUM_PE            = 16;

    typedef struct packed {
        logic                   valid;
        logic [CACHE_WIDTH-1:0] data;
    } acc_bus_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/conv_read_sequencer_valid_delay_line.sv
// One-bit shift register that delays the read strobe to line up with buffer
// read data; any_set_o reports beats still in flight.
module valid_delay_line
    import conv_read_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clear_i,
    input  logic din_i,
    output logic dout_o,
    output logic any_set_o
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (clear_i) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout_o    = sr_q[DEPTH-1];
    assign any_set_o = |sr_q;

endmodule

// File: rtl/conv_read_sequencer.sv
// Walks every image line and every weight address per line, issuing buffer
// reads with back-pressure, then waits for the downstream pipeline to drain.
module conv_read_sequencer #(
    parameter int WEIGHT_ADDR_WIDTH = conv_read_sequencer_pkg::WEIGHT_ADDR_WIDTH,
    parameter int IMAGE_ADDR_WIDTH  = conv_read_sequencer_pkg::IMAGE_ADDR_WIDTH,
    parameter int RD_LATENCY        = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WEIGHT_ADDR_WIDTH-1:0] max_weight_buffer_addr,
    input  logic [IMAGE_ADDR_WIDTH-1:0]  last_image_addr,
    input  logic                         pipeline_full,
    input  logic                         pipeline_empty,
    output logic                         rd_en,
    output logic [WEIGHT_ADDR_WIDTH-1:0] addr_a,
    output logic [IMAGE_ADDR_WIDTH-1:0]  addr_b,
    output logic                         valid,
    output logic                         busy,
    output logic                         filters_finished
);

    import conv_read_sequencer_pkg::*;

    seq_state_t                   state_q;
    logic [WEIGHT_ADDR_WIDTH-1:0] cnt_a_q;
    logic [WEIGHT_ADDR_WIDTH-1:0] max_w_q;
    logic [IMAGE_ADDR_WIDTH-1:0]  cnt_b_q;
    logic [IMAGE_ADDR_WIDTH-1:0]  last_img_q;
    logic                         issue;
    logic                         in_flight;

    // Issue is combinational so a stall cycle never costs an extra bubble.
    assign issue = (state_q == ISSUE) && !pipeline_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            max_w_q    <= '0;
            last_img_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        max_w_q    <= max_weight_buffer_addr;
                        last_img_q <= last_image_addr;
                        cnt_a_q    <= '0;
                        cnt_b_q    <= '0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!pipeline_full) begin
                        if (cnt_a_q == max_w_q) begin
                            cnt_a_q <= '0;
                            if (cnt_b_q == last_img_q) begin
                                state_q <= DRAIN;
                            end else begin
                                cnt_b_q <= cnt_b_q + IMAGE_ADDR_WIDTH'(1);
                            end
                        end else begin
                            cnt_a_q <= cnt_a_q + WEIGHT_ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!in_flight && pipeline_empty) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH(RD_LATENCY)
    ) u_valid_delay_line (
        .clk      (clk),
        .clear_i  (reset),
        .din_i    (issue),
        .dout_o   (valid),
        .any_set_o(in_flight)
    );

    assign rd_en            = issue;
    assign addr_a           = cnt_a_q;
    assign addr_b           = cnt_b_q;
    assign busy             = (state_q != IDLE);
    assign filters_finished = (state_q == DONE);

endmodule

// File: tb/tb_conv_read_sequencer.sv
// Scoreboard bench for conv_read_sequencer: stimulus pushes expected beats,
// a negedge monitor pops and compares addresses and valid alignment.
module tb_conv_read_sequencer;

    localparam int WA  = 13;
    localparam int IA  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WA-1:0] max_w = '0;
    logic [IA-1:0] last_img = '0;
    logic          pipeline_full = 1'b0;
    logic          pipeline_empty = 1'b1;
    logic          rd_en;
    logic [WA-1:0] addr_a;
    logic [IA-1:0] addr_b;
    logic          valid;
    logic          busy;
    logic          filters_finished;

    logic [WA+IA-1:0] aq[$];
    int               vq[$];
    int               cyc = 0;
    int               nvec = 0;
    int               nerr = 0;
    int               beat_cnt = 0;
    int               valid_cnt = 0;
    int               busy_cnt = 0;
    int               done_cnt = 0;
    int               done_base = 0;

    conv_read_sequencer #(
        .WEIGHT_ADDR_WIDTH(WA),
        .IMAGE_ADDR_WIDTH (IA),
        .RD_LATENCY       (LAT)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .max_weight_buffer_addr(max_w),
        .last_image_addr       (last_img),
        .pipeline_full         (pipeline_full),
        .pipeline_empty        (pipeline_empty),
        .rd_en                 (rd_en),
        .addr_a                (addr_a),
        .addr_b                (addr_b),
        .valid                 (valid),
        .busy                  (busy),
        .filters_finished      (filters_finished)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: addresses of every issued beat, valid timing, stall behaviour.
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (vq.size() > 0) && (vq[0] == cyc);
        if (valid || exp_v) begin
            chk("valid_align", int'(valid), int'(exp_v));
            if (exp_v) void'(vq.pop_front());
        end
        if (valid) valid_cnt++;
        if (rd_en) begin
            if (aq.size() == 0) begin
                chk("beat_unexpected", 1, 0);
            end else begin
                chk("beat_addr", int'({addr_b, addr_a}), int'(aq.pop_front()));
            end
            beat_cnt++;
            vq.push_back(cyc + LAT);
        end
        if (pipeline_full) chk("rd_en_under_full", int'(rd_en), 0);
        if (busy) busy_cnt++;
        if (filters_finished) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [WA-1:0] mw, input logic [IA-1:0] li);
        logic [IA-1:0] bb;
        logic [WA-1:0] ab;
        for (int b = 0; b <= int'(li); b++) begin
            for (int a = 0; a <= int'(mw); a++) begin
                bb = IA'(b);
                ab = WA'(a);
                aq.push_back({bb, ab});
            end
        end
        beat_cnt  = 0;
        valid_cnt = 0;
        busy_cnt  = 0;
        done_base = done_cnt;
        max_w     = mw;
        last_img  = li;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int exp_beats);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == done_base) chk("done_timeout", 0, 1);
        tick();
        tick();
        chk("beats", beat_cnt, exp_beats);
        chk("valids", valid_cnt, exp_beats);
        chk("done_pulses", done_cnt - done_base, 1);
        chk("queue_drained", aq.size(), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(filters_finished), 0);
        chk("rst_addr_a", int'(addr_a), 0);
        chk("rst_addr_b", int'(addr_b), 0);
        reset = 1'b0;
        tick();

        // 1: 4x2 pass, no stalls
        start_pass(13'd3, 10'd1);
        chk("busy_rise", int'(busy), 1);
        wait_done(100, 8);

        // 2: single beat; busy = issue(1) + drain(LAT+1) + done(1)
        start_pass(13'd0, 10'd0);
        wait_done(100, 1);
        chk("busy_cycles_single", busy_cnt, 5);

        // 3: stall on ISSUE cycles 3-5
        start_pass(13'd3, 10'd1);
        tick();
        tick();
        pipeline_full = 1'b1;
        tick();
        tick();
        tick();
        pipeline_full = 1'b0;
        wait_done(100, 8);

        // 4: downstream not empty holds DRAIN
        start_pass(13'd1, 10'd0);
        pipeline_empty = 1'b0;
        for (int n = 0; n < 50 && valid_cnt < 2; n++) tick();
        chk("drain_valids_seen", valid_cnt, 2);
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("drain_hold_done", int'(filters_finished), 0);
            chk("drain_hold_busy", int'(busy), 1);
        end
        pipeline_empty = 1'b1;
        tick();
        chk("done_after_empty", int'(filters_finished), 1);
        wait_done(20, 2);

        // 5: second start mid-pass with other limits is ignored
        start_pass(13'd2, 10'd1);
        tick();
        max_w    = 13'd7;
        last_img = 10'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(100, 6);

        // 7: start together with back-pressure, stall on the final issue
        pipeline_full = 1'b1;
        start_pass(13'd1, 10'd1);
        tick();
        tick();
        pipeline_full = 1'b0;
        tick();
        tick();
        tick();
        pipeline_full = 1'b1;
        tick();
        tick();
        pipeline_full = 1'b0;
        wait_done(100, 4);

        // 6: reset during beat 5, then a fresh full pass
        start_pass(13'd3, 10'd1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        aq.delete();
        vq.delete();
        chk("mid_rst_rd_en", int'(rd_en), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_addr_a", int'(addr_a), 0);
        chk("mid_rst_addr_b", int'(addr_b), 0);
        tick();
        chk("mid_rst_valid2", int'(valid), 0);
        reset = 1'b0;
        valid_cnt = 0;
        repeat (6) tick();
        chk("no_stale_valid", valid_cnt, 0);
        start_pass(13'd3, 10'd1);
        wait_done(100, 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
